div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//  Multi-cycle 32-bit divide sequencer beside the EX stage. Serves DIV/DIVU.
//  EX raises a start request with operands. This block runs one restoring step
//  per cycle and asserts stallreq_o so the pipeline holds until the result is ready.
//  It returns {remainder, quotient} for the HI/LO write path.
//  It also drops in-flight work when the instruction is annulled, for example
//  on a flush or on a branch-delay-slot cancel.
// PARAMETERS
//  WIDTH      32   operand width; the result is 2*WIDTH wide
//  CNT_W      6    iteration counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
//  clk           in   1        clock; all state changes on the rising edge
//  rst           in   1        synchronous, active-high reset (`RstEnable = 1'b1)
//  signed_div_i  in   1        1 = signed (DIV), 0 = unsigned (DIVU)
//  opdata1_i     in   WIDTH    dividend
//  opdata2_i     in   WIDTH    divisor
//  start_i       in   1        request; held high by EX until ready_o is seen
//  annul_i       in   1        abandon the current or requested operation
//  result_o      out  2*WIDTH  {remainder[63:32], quotient[31:0]}
//  ready_o       out  1        result_o is valid
//  stallreq_o    out  1        to pipeline control: hold IF..EX stages
// BEHAVIOUR
//  Reset
//   - state=FREE; result_o=0; ready_o=0; counter=0; working regs=0.
//   - Reset takes priority over every other input in any state, including mid-op.
//  States: FREE, BYZERO, ON, END (encodings come from the package).
//  FREE
//   - start_i=1, annul_i=0, divisor==0: go to BYZERO.
//   - start_i=1, annul_i=0, divisor!=0: go to ON and latch the operands.
//     If signed_div_i=1, latch |dividend| and |divisor| (two's-complement
//     negate when bit31=1).
//     Latch sign flags and the raw operand sign bits; set counter=0.
//   - start_i=1 together with annul_i=1: annul wins; stay in FREE.
//  BYZERO
//   - Unconditionally go to END next cycle with quotient=0, remainder=0.
//  ON
//   - Each cycle performs one restoring step on a 65-bit working reg
//     {partial_rem, dividend_shift}:
//     trial = partial_rem - divisor.
//     trial >= 0: keep trial and shift in 1; else shift in 0.
//   - counter increments each step. After the 32nd step (counter==32), go to END.
//   - Sign fix-up applies in the END transition, signed ops only:
//     quotient negated iff the dividend and divisor signs differ;
//     remainder takes the sign of the dividend.
//   - annul_i=1 or start_i=0 in any ON cycle: go to FREE next edge.
//     No result is produced and ready_o stays 0.
//  END
//   - ready_o=1; result_o holds the final value.
//   - Stays in END while start_i=1.
//   - When start_i=0: go to FREE; ready_o=0 and result_o=0 on that edge.
//   - annul_i in END: go to FREE as above.
//  Latency (start_i first sampled high at edge N)
//   - Nonzero divisor: ready_o is first high after edge N+33.
//   - Zero divisor: ready_o is first high after edge N+2.
//   - Back-to-back operations need start_i low for at least one cycle between them.
//  stallreq_o: combinational, = start_i & ~annul_i & ~ready_o.
//   - It is 0 in reset and 0 in END.
//  Arithmetic and width rules
//   - All arithmetic is mod 2^32.
//   - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
//     No exception or flag is raised.
//   - Divide-by-zero produces no exception; software checks for it.
// STRUCTURE
//  Shared defines package (defines.v)
//   - `DivFree, `DivByZero, `DivOn, `DivEnd (2-bit state encodings).
//   - `DivResultReady / `DivResultNotReady, `DivStart / `DivStop.
//   - `DoubleRegBus (63:0).
//  Sub-module div_step: combinational single restoring iteration.
//   - Inputs: 65-bit working reg, divisor.
//   - Output: next working reg.
//  The FSM, counter and sign fix-up stay in div_ctrl.
// TESTING
//  Unsigned 100/7, start held:
//   - result_o=0x00000002_0000000E; ready_o rises exactly 33 cycles after
//     start_i is first sampled.
//   - stallreq_o=1 throughout the wait, then 0.
//  Signed -7/2 (0xFFFFFFF9 / 0x00000002):
//   - quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//  Signed 0x80000000 / 0xFFFFFFFF:
//   - result_o=0x00000000_80000000, with no stall beyond normal latency.
//  Divisor 0:
//   - ready_o is first high after edge N+2 with result_o=0.
//   - Dropping start_i returns to FREE with ready_o=0.
//  annul_i pulsed in cycle 10 of ON:
//   - FREE next edge; ready_o never asserts.
//   - A following 9/3 unsigned op returns 0x00000000_00000003 with full latency.
//  rst asserted in cycle 20 of ON:
//   - All outputs 0 after the edge.
//  start_i=1 with annul_i=1 in FREE:
//   - State stays FREE; stallreq_o=0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared constants for the multi-cycle divide sequencer: the 2-bit FSM state
// encodings, result-ready / start-stop levels and the double register width
// used by the HI/LO write path.
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

   // FSM state encodings for the divide sequencer
   localparam logic [1:0] DIV_FREE   = 2'b00;
   localparam logic [1:0] DIV_BYZERO = 2'b01;
   localparam logic [1:0] DIV_ON     = 2'b10;
   localparam logic [1:0] DIV_END    = 2'b11;

   // Handshake levels
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   // Width of the {HI, LO} result bus
   localparam int DOUBLE_REG_W = 64;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   work      in   2*WIDTH+1  {partial_rem, dividend_shift} before the step
//   divisor   in   WIDTH      (absolute) divisor
//   work_next out  2*WIDTH+1  working register after the step
// The upper WIDTH+1 bits hold the partial remainder, the lower WIDTH bits hold
// the dividend bits still to be consumed, with quotient bits shifted in at the
// bottom.
// -----------------------------------------------------------------------------
module div_step
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] work,
   input  logic [WIDTH-1:0] divisor,
   output logic [2*WIDTH:0] work_next
);

   logic [2*WIDTH:0] shifted;
   logic [WIDTH:0]   upper;
   logic [WIDTH+1:0] trial;

   // Shift left one place, then try subtracting the divisor from the partial
   // remainder. The extra top bit of trial is its sign: clear means the
   // subtraction fits, so keep it and shift in a 1; otherwise restore.
   always_comb begin
      shifted   = {work[2*WIDTH-1:0], 1'b0};
      upper     = shifted[2*WIDTH:WIDTH];
      trial     = {1'b0, upper} - {2'b00, divisor};
      work_next = shifted;
      if (!trial[WIDTH+1]) begin
         work_next = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU sequencer sitting beside EX. One restoring step per
// cycle; the pipeline is stalled until the {remainder, quotient} result is
// ready. In-flight work is dropped on annul or when EX withdraws start.
//   clk          in   1        clock
//   rst          in   1        synchronous active-high reset
//   signed_div_i in   1        1 = DIV (signed), 0 = DIVU
//   opdata1_i    in   WIDTH    dividend
//   opdata2_i    in   WIDTH    divisor
//   start_i      in   1        request, held until ready_o
//   annul_i      in   1        abandon current/requested operation
//   result_o     out  2*WIDTH  {remainder, quotient}
//   ready_o      out  1        result_o valid
//   stallreq_o   out  1        hold IF..EX
// -----------------------------------------------------------------------------
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_o
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] counter;
   logic [2*WIDTH:0] work;
   logic [WIDTH-1:0] divisor;
   logic             op_signed;
   logic             dividend_neg;
   logic             divisor_neg;

   logic [2*WIDTH:0] step_next;
   logic [WIDTH-1:0] abs_dividend;
   logic [WIDTH-1:0] abs_divisor;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .work      (work),
      .divisor   (divisor),
      .work_next (step_next)
   );

   // Magnitudes of the incoming operands; only signed ops with a set sign bit
   // get negated, so DIVU operands pass straight through.
   always_comb begin
      abs_dividend = opdata1_i;
      abs_divisor  = opdata2_i;
      if (signed_div_i && opdata1_i[WIDTH-1]) begin
         abs_dividend = -opdata1_i;
      end
      if (signed_div_i && opdata2_i[WIDTH-1]) begin
         abs_divisor = -opdata2_i;
      end
   end

   // Sign fix-up applied to the output of the final step: quotient is negative
   // when the operand signs differ, remainder follows the dividend. The
   // 0x80000000 / -1 case wraps back to 0x80000000 naturally.
   always_comb begin
      quot_fix = step_next[WIDTH-1:0];
      rem_fix  = step_next[2*WIDTH-1:WIDTH];
      if (op_signed && (dividend_neg ^ divisor_neg)) begin
         quot_fix = -step_next[WIDTH-1:0];
      end
      if (op_signed && dividend_neg) begin
         rem_fix = -step_next[2*WIDTH-1:WIDTH];
      end
   end

   // Main sequencer. The 32nd step and the sign fix-up land together on the
   // edge that enters END; ready_o/result_o are then registered while in END,
   // which gives the same one-cycle END settle for both the normal and the
   // divide-by-zero path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= DIV_FREE;
         result_o     <= '0;
         ready_o      <= DIV_RESULT_NOT_READY;
         counter      <= '0;
         work         <= '0;
         divisor      <= '0;
         op_signed    <= 1'b0;
         dividend_neg <= 1'b0;
         divisor_neg  <= 1'b0;
      end else begin
         case (state)
            DIV_FREE: begin
               ready_o  <= DIV_RESULT_NOT_READY;
               result_o <= '0;
               if (start_i == DIV_START && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DIV_BYZERO;
                  end else begin
                     state        <= DIV_ON;
                     counter      <= '0;
                     work         <= {{(WIDTH+1){1'b0}}, abs_dividend};
                     divisor      <= abs_divisor;
                     op_signed    <= signed_div_i;
                     dividend_neg <= opdata1_i[WIDTH-1];
                     divisor_neg  <= opdata2_i[WIDTH-1];
                  end
               end
            end
            DIV_BYZERO: begin
               work  <= '0;
               state <= DIV_END;
            end
            DIV_ON: begin
               if (annul_i || start_i == DIV_STOP) begin
                  state <= DIV_FREE;
               end else if (counter == LAST_STEP) begin
                  work    <= {1'b0, rem_fix, quot_fix};
                  counter <= counter + 1'b1;
                  state   <= DIV_END;
               end else begin
                  work    <= step_next;
                  counter <= counter + 1'b1;
               end
            end
            DIV_END: begin
               if (annul_i || start_i == DIV_STOP) begin
                  state    <= DIV_FREE;
                  ready_o  <= DIV_RESULT_NOT_READY;
                  result_o <= '0;
               end else begin
                  ready_o  <= DIV_RESULT_READY;
                  result_o <= work[2*WIDTH-1:0];
               end
            end
            default: begin
               state <= DIV_FREE;
            end
         endcase
      end
   end

   // Stall while EX is asking and the result is not yet available
   assign stallreq_o = start_i & ~annul_i & ~ready_o;

endmodule
